// File: rtl/obuft_share_arbiter.sv
// obuft_share_arbiter
//   Round-robin arbiter sharing one tristate output buffer (OBUFT/OBUFTDS
//   class) between NREQ requesters. Every ownership change is wrapped in
//   high-Z turnaround windows, and the drive time is capped while other
//   requesters are waiting.
//
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   req    : level request per requester
//   data   : per-requester output bit (only the owner's bit is used)
//   grant  : one-hot ownership, zero when unowned
//   out_i  : buffer data input
//   out_t  : buffer tristate control, 1 = high-Z
//   busy   : high whenever the arbiter is not idle
module obuft_share_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] data,
   output logic [NREQ-1:0] grant,
   output logic            out_i,
   output logic            out_t,
   output logic            busy
);

   localparam int unsigned IW = (NREQ > 1)        ? $clog2(NREQ)        : 1;
   localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
   localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENABLE  = 2'd1,
      DRIVE   = 2'd2,
      DISABLE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            out_i_q, out_i_d;
   logic            out_t_q, out_t_d;
   logic            busy_q,  busy_d;
   logic [IW-1:0]   last_q,  last_d;
   logic [TW-1:0]   turn_q,  turn_d;
   logic [HW-1:0]   hold_q,  hold_d;

   logic [IW-1:0]   scan_idx;
   logic [IW-1:0]   win_idx;
   logic [NREQ-1:0] win_onehot;
   logic            found;
   logic            req_g;
   logic            data_g;
   logic            others_req;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      found    = 1'b0;
      scan_idx = '0;
      win_idx  = last_q;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         scan_idx = IW'((32'(last_q) + i) % NREQ);
         if (!found && req[scan_idx]) begin
            found   = 1'b1;
            win_idx = scan_idx;
         end
      end
      win_onehot = NREQ'(1) << win_idx;
   end

   // last_q doubles as the current owner index: it is loaded with the
   // winner on the same edge that sets grant and is stable until the next
   // arbitration.
   assign req_g      = req[last_q];
   assign data_g     = data[last_q];
   assign others_req = |(req & ~grant_q);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      turn_d  = turn_q;
      hold_d  = '0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = ENABLE;
               grant_d = win_onehot;
               last_d  = win_idx;
               turn_d  = TURN_LOAD;
            end
         end

         ENABLE: begin
            if (!req_g) begin
               state_d = DISABLE;
               grant_d = '0;
               turn_d  = TURN_LOAD;
            end else if (turn_q == '0) begin
               state_d = DRIVE;
            end else begin
               turn_d = turn_q - TW'(1);
            end
         end

         DRIVE: begin
            // Owner release and contended hold limit share one exit path.
            if (!req_g || ((hold_q == HOLD_MAX) && others_req)) begin
               state_d = DISABLE;
               grant_d = '0;
               turn_d  = TURN_LOAD;
            end else begin
               hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
            end
         end

         DISABLE: begin
            grant_d = '0;
            if (turn_q == '0) begin
               state_d = IDLE;
            end else begin
               turn_d = turn_q - TW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      // Outputs are registered images of the next state, so out_t is only
      // low while the state register holds DRIVE.
      out_t_d = (state_d != DRIVE);
      busy_d  = (state_d != IDLE);
      out_i_d = (state_d == DRIVE) ? data_g : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         out_i_q <= 1'b0;
         out_t_q <= 1'b1;
         busy_q  <= 1'b0;
         last_q  <= LAST_RST;
         turn_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         out_i_q <= out_i_d;
         out_t_q <= out_t_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         turn_q  <= turn_d;
         hold_q  <= hold_d;
      end
   end

   assign grant = grant_q;
   assign out_i = out_i_q;
   assign out_t = out_t_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_obuft_share_arbiter.sv
// tb_obuft_share_arbiter
//   Directed bench for obuft_share_arbiter with NREQ=4, TURN_CYCLES=2,
//   HOLD_CYCLES=4. Inputs change and outputs are sampled 1 time unit after
//   each rising edge; "E<n>" below counts edges from the first edge at
//   which the idle arbiter samples a request.
module tb_obuft_share_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] data;
   logic [3:0] grant;
   logic       out_i;
   logic       out_t;
   logic       busy;

   int pass_cnt;
   int total_cnt;

   logic [3:0] exp_g [0:18];
   logic       exp_t [0:18];

   obuft_share_arbiter #(
      .NREQ        (4),
      .TURN_CYCLES (2),
      .HOLD_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .data  (data),
      .grant (grant),
      .out_i (out_i),
      .out_t (out_t),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_idle();
      req = 4'b0000;
      repeat (5) tick();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      req   = 4'b0000;
      data  = 4'b0000;
      #1 rst_n = 1'b0;
      tick();
      total_cnt++;
      if ({grant, out_t, out_i, busy} !== 7'b0000_100)
         $display("FAIL reset_state: got grant=%b t=%b i=%b busy=%b want grant=0000 t=1 i=0 busy=0", grant, out_t, out_i, busy);
      else pass_cnt++;
      rst_n = 1'b1;

      // Take requester 0 into DRIVE with data high, then reset mid-cycle.
      req  = 4'b1111;
      data = 4'b0001;
      tick();
      total_cnt++;
      if (grant !== 4'b0001)
         $display("FAIL reset_first_grant: got %b want 0001", grant);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if ({out_t, out_i} !== 2'b01)
         $display("FAIL reset_pre_drive: got t=%b i=%b want t=0 i=1", out_t, out_i);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({grant, out_t, out_i, busy} !== 7'b0000_100)
         $display("FAIL reset_async: got grant=%b t=%b i=%b busy=%b want grant=0000 t=1 i=0 busy=0", grant, out_t, out_i, busy);
      else pass_cnt++;
      #1 rst_n = 1'b1;

      // Pointer restarts at NREQ-1, so requester 0 wins again.
      tick();
      total_cnt++;
      if ({grant, busy} !== 5'b0001_1)
         $display("FAIL reset_regrant: got grant=%b busy=%b want grant=0001 busy=1", grant, busy);
      else pass_cnt++;
      data = 4'b0000;
      settle_idle();
   endtask

   task automatic test_single();
      logic [4:0] pat;
      pat  = 5'b01101;
      req  = 4'b0010;
      data = 4'b0000;
      tick(); // E0
      total_cnt++;
      if ({grant, out_t, busy} !== 6'b0010_1_1)
         $display("FAIL single_e0: got grant=%b t=%b busy=%b want grant=0010 t=1 busy=1", grant, out_t, busy);
      else pass_cnt++;
      data[1] = 1'b0;
      tick(); // E1
      total_cnt++;
      if (out_t !== 1'b1)
         $display("FAIL single_e1_t: got %b want 1", out_t);
      else pass_cnt++;
      data[1] = 1'b1;
      tick(); // E2
      total_cnt++;
      if ({out_t, out_i} !== 2'b01)
         $display("FAIL single_e2: got t=%b i=%b want t=0 i=1", out_t, out_i);
      else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         data[1] = pat[k];
         data[0] = ~pat[k]; // non-owner bit must be ignored
         tick();
         total_cnt++;
         if ({out_t, out_i} !== {1'b0, pat[k]})
            $display("FAIL single_track_%0d: got t=%b i=%b want t=0 i=%b", k, out_t, out_i, pat[k]);
         else pass_cnt++;
      end
      req  = 4'b0000;
      data = 4'b0000;
      tick();
      total_cnt++;
      if ({grant, out_t, out_i, busy} !== 7'b0000_101)
         $display("FAIL single_release: got grant=%b t=%b i=%b busy=%b want grant=0000 t=1 i=0 busy=1", grant, out_t, out_i, busy);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (busy !== 1'b0)
         $display("FAIL single_idle_busy: got %b want 0", busy);
      else pass_cnt++;
      settle_idle();
   endtask

   task automatic test_contention();
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                4'b0000, 4'b0000, 4'b0000,
                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                4'b0000, 4'b0000, 4'b0000, 4'b0001};
      exp_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1};
      pulse_reset();
      req = 4'b0101;
      for (int e = 0; e < 19; e++) begin
         tick();
         total_cnt++;
         if ({grant, out_t} !== {exp_g[e], exp_t[e]})
            $display("FAIL contention_e%0d: got grant=%b t=%b want grant=%b t=%b", e, grant, out_t, exp_g[e], exp_t[e]);
         else pass_cnt++;
         if (e == 8) begin
            total_cnt++;
            if (busy !== 1'b0)
               $display("FAIL contention_idle_busy: got %b want 0", busy);
            else pass_cnt++;
         end
      end
      settle_idle();
   endtask

   task automatic test_rotation_wrap();
      req = 4'b1000;
      tick();
      total_cnt++;
      if (grant !== 4'b1000)
         $display("FAIL wrap_owner3: got %b want 1000", grant);
      else pass_cnt++;
      repeat (3) tick();
      settle_idle();
      req = 4'b1001;
      tick();
      total_cnt++;
      if (grant !== 4'b0001)
         $display("FAIL wrap_next: got %b want 0001", grant);
      else pass_cnt++;
      settle_idle();
   endtask

   task automatic test_uncontended_hold();
      int bad;
      bad = 0;
      req = 4'b0100;
      tick(); // E0
      total_cnt++;
      if (grant !== 4'b0100)
         $display("FAIL hold_grant: got %b want 0100", grant);
      else pass_cnt++;
      tick(); // E1
      for (int e = 2; e < 50; e++) begin
         tick();
         if ({grant, out_t} !== 5'b0100_0) bad++;
      end
      total_cnt++;
      if (bad != 0)
         $display("FAIL hold_48_drive: got %0d bad cycles want 0 (last grant=%b t=%b)", bad, grant, out_t);
      else pass_cnt++;
      req = 4'b0101;
      tick();
      total_cnt++;
      if ({grant, out_t, busy} !== 6'b0000_1_1)
         $display("FAIL hold_saturated_exit: got grant=%b t=%b busy=%b want grant=0000 t=1 busy=1", grant, out_t, busy);
      else pass_cnt++;
      settle_idle();
   endtask

   task automatic test_enable_abort();
      int drove;
      drove = 0;
      req = 4'b1000;
      tick(); // E0
      total_cnt++;
      if ({grant, out_t, busy} !== 6'b1000_1_1)
         $display("FAIL abort_e0: got grant=%b t=%b busy=%b want grant=1000 t=1 busy=1", grant, out_t, busy);
      else pass_cnt++;
      req = 4'b0000;
      tick(); // E1
      total_cnt++;
      if ({grant, out_t, busy} !== 6'b0000_1_1)
         $display("FAIL abort_e1: got grant=%b t=%b busy=%b want grant=0000 t=1 busy=1", grant, out_t, busy);
      else pass_cnt++;
      if (out_t === 1'b0) drove++;
      tick(); // E2
      total_cnt++;
      if (busy !== 1'b1)
         $display("FAIL abort_e2_busy: got %b want 1", busy);
      else pass_cnt++;
      if (out_t === 1'b0) drove++;
      tick(); // E3
      if (out_t === 1'b0) drove++;
      total_cnt++;
      if ({grant, busy, drove} !== {4'b0000, 1'b0, 32'd0})
         $display("FAIL abort_idle: got grant=%b busy=%b drove=%0d want grant=0000 busy=0 drove=0", grant, busy, drove);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_single();
      test_contention();
      test_rotation_wrap();
      test_uncontended_hold();
      test_enable_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
